// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the calculator button inputs.
interface button_conditioner_if #(
    parameter int NUM_BTN = 3
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and press/release pulse generator.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while held.
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef BTN_AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_NEXT  = HW'(REPEAT_DELAY + REPEAT_PERIOD);
`endif

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        HELD_HIGH,
        WAIT_LOW
    } state_e;

    logic [NUM_BTN-1:0] level_v;
    logic [NUM_BTN-1:0] press_v;
    logic [NUM_BTN-1:0] release_v;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        state_e                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;
`ifdef BTN_AUTOREPEAT_EN
        logic [HW-1:0]          hold_q, hold_d, hold_inc;

        assign hold_inc = hold_q + HOLD_ONE;
`endif

        assign sync = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q    <= '0;
                state_q   <= IDLE_LOW;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                hold_q    <= '0;
`endif
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], btn.btn_raw[i]};
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
                hold_q    <= hold_d;
`endif
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            hold_d    = hold_q;
`endif
            unique case (state_q)
                IDLE_LOW: begin
                    if (sync) begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_MAX) begin
                        state_d = HELD_HIGH;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        hold_d  = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD_HIGH: begin
                    // a bounce low freezes the hold counter where it is
                    if (!sync) begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (hold_inc == HOLD_NEXT) begin
                        hold_d  = HOLD_FIRST;
                        press_d = 1'b1;
                    end else begin
                        hold_d  = hold_inc;
                        press_d = (hold_inc == HOLD_FIRST);
                    end
`endif
                end
                WAIT_LOW: begin
                    if (sync) begin
                        state_d = HELD_HIGH;
                        cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
                        hold_d  = '0;
`endif
                    end else if (cnt_q >= CNT_MAX) begin
                        state_d   = IDLE_LOW;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        hold_d    = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                end
            endcase
        end

        assign level_v[i]   = level_q;
        assign press_v[i]   = press_q;
        assign release_v[i] = release_q;
    end

    assign btn.btn_level   = level_v;
    assign btn.btn_press   = press_v;
    assign btn.btn_release = release_v;
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end input stage for the calculator top level. Cleans raw, bouncy, asynchronous push-button signals (confirm, mode_change, and any further buttons) before they reach the operand-entry and display-control logic. Per button it synchronises, debounces and emits a stable level plus single-cycle press/release pulses. One instance per board; outputs drive the calculator's button inputs directly.

Parameters:
NUM_BTN, 3, number of independent button channels
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a change (>=1; 10 ms at 100 MHz)
REPEAT_DELAY, 50000000, cycles held before first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN)
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with BTN_AUTOREPEAT_EN)

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
btn_raw  input  NUM_BTN  raw asynchronous button pins, 1 = pressed
btn_level  output  NUM_BTN  debounced button level
btn_press  output  NUM_BTN  one-cycle pulse on accepted 0->1 transition (and auto-repeat)
btn_release  output  NUM_BTN  one-cycle pulse on accepted 1->0 transition

Behaviour:
- Reset: synchroniser flops, counters, btn_level, btn_press, btn_release all 0; every channel FSM to IDLE_LOW. Reset mid-debounce or mid-hold discards progress; no pulse is emitted on the reset cycle or the cycle after.
- Channels fully independent; simultaneous events on several channels give simultaneous pulses in the same cycle.
- Synchroniser: btn_raw[i] passes through SYNC_STAGES flops; sync[i] is the last stage.
- Per-channel FSM, states IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW:
  - IDLE_LOW: sync=1 -> WAIT_HIGH, count=1.
  - WAIT_HIGH: sync=0 -> IDLE_LOW, count=0 (glitch rejected). sync=1 and count=DEBOUNCE_CYCLES -> HELD_HIGH; btn_level=1 and btn_press=1 registered on that edge. Otherwise count++.
  - HELD_HIGH: sync=0 -> WAIT_LOW, count=1.
  - WAIT_LOW: sync=1 -> HELD_HIGH, count=0. sync=0 and count=DEBOUNCE_CYCLES -> IDLE_LOW; btn_level=0 and btn_release=1 registered. Otherwise count++.
- DEBOUNCE_CYCLES=1 degenerates correctly: accept on the first differing sample.
- Latency: raw change stable from edge N -> btn_level/pulse visible after edge N+SYNC_STAGES+DEBOUNCE_CYCLES. Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- btn_press/btn_release are high for exactly one cycle per accepted transition, never both in the same cycle on one channel.
- Counter width $clog2(DEBOUNCE_CYCLES+1); saturates, never wraps.
- Button held through reset deassertion is detected as a fresh press after the normal latency.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: a per-channel hold counter runs in HELD_HIGH. After REPEAT_DELAY cycles in HELD_HIGH, btn_press pulses once. It then pulses again every REPEAT_PERIOD cycles while held. The hold counter clears on entering HELD_HIGH, on leaving it, and on reset. Bounce into WAIT_LOW pauses the hold counter. Return to HELD_HIGH without release resets the hold counter and emits no new press.
- Not defined: no hold counter is synthesised; exactly one btn_press per accepted press regardless of hold duration.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2: reset 3 cycles, raise btn_raw[0] at edge 10 and hold -> btn_level[0]=1 and btn_press[0]=1 at edge 16 only, btn_press[0]=0 at edge 17; other channels stay 0.
- Bounce: btn_raw[1] high for 3 cycles, low 2, high 3, low -> no btn_level/btn_press change on channel 1.
- Release: after held press, drop btn_raw[0] steady -> btn_release[0] one-cycle pulse 6 edges later, btn_level[0]=0; a 2-cycle low glitch in HELD_HIGH produces no release.
- Simultaneous: btn_raw=3'b101 at the same edge -> btn_press=3'b101 in the same cycle, each one cycle wide.
- Reset mid-operation: assert reset during WAIT_HIGH (count=2) with button still held -> outputs 0; after reset release a press pulse follows 6 edges later.
- BTN_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=8: hold 60 cycles after accept -> press pulses at accept, accept+20, +28, +36, +44, +52; none after release. Without the macro -> single pulse.
